ws2812_stream_driver: RTL and testbench

Parametrised successor to the single-pixel WS2812B output stage. It drives one addressable-LED data line at a configurable pixel width (24-bit RGB or 32-bit RGBW) and configurable bit timing. A small pixel FIFO lets the CPU-side peripheral push several pixels back-to-back without gaps between them. Each pixel carries a latch flag that triggers the reset/latch low period after it.

---
 rtl/ws2812_stream_driver.sv | 176 +++++++++++++++++
 tb/tb_ws2812_stream_driver.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_stream_driver.sv
// WS2812-style serial LED driver with a small pixel FIFO, configurable pixel width and bit timing.
// Optional build macro WS2812_AUTO_LATCH_EN: an underrun after a non-latch pixel enters the latch period.
module ws2812_stream_driver #(
  parameter int CLOCK_MHZ      = 64,
  parameter int BITS_PER_PIXEL = 24,
  parameter int FIFO_DEPTH     = 4,
  parameter int T0H_NS         = 400,
  parameter int T1H_NS         = 800,
  parameter int PERIOD_NS      = 1250,
  parameter int RESET_NS       = 325000,
  localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BITS_PER_PIXEL-1:0] data_in,
  input  logic                      latch_in,
  input  logic                      valid,
  output logic                      ready,
  output logic [LVL_W-1:0]          fifo_level,
  output logic                      busy,
  output logic                      led
);

  localparam int CYC_PERIOD = (CLOCK_MHZ * PERIOD_NS + 500) / 1000;
  localparam int CYC_T0H    = (CLOCK_MHZ * T0H_NS + 500) / 1000;
  localparam int CYC_T1H    = (CLOCK_MHZ * T1H_NS + 500) / 1000;
  localparam int CYC_RESET  = (CLOCK_MHZ * RESET_NS + 500) / 1000;
  localparam int CNT_W      = $clog2(CYC_RESET + 1);
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BIT_W      = $clog2(BITS_PER_PIXEL);
  localparam int ENT_W      = BITS_PER_PIXEL + 1;

  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(CYC_PERIOD - 1);
  localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(CYC_RESET - 1);
  localparam logic [CNT_W-1:0] T0H_LEN     = CNT_W'(CYC_T0H);
  localparam logic [CNT_W-1:0] T1H_LEN     = CNT_W'(CYC_T1H);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(BITS_PER_PIXEL - 1);
  localparam logic [LVL_W-1:0] LVL_FULL    = LVL_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  if (CYC_T1H >= CYC_PERIOD || (BITS_PER_PIXEL != 24 && BITS_PER_PIXEL != 32)) begin : g_bad_cfg
    $error("ws2812_stream_driver: T1H must be shorter than the bit period and pixel width 24 or 32");
  end

  // Pixel FIFO: entry is {latch flag, pixel data}
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full, empty, push, pop;
  logic [ENT_W-1:0] rd_data;

  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);
  assign push    = valid && !full;
  assign rd_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {latch_in, data_in};
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Serializer state
  logic [1:0]                state_q, state_d;
  logic [CNT_W-1:0]          time_q, time_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
  logic                      latch_q, latch_d;
  logic                      led_q, led_d;
  logic                      load;
  logic [CNT_W-1:0]          hi_len;

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    latch_d = latch_q;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load = !empty;
      end
      ST_SEND: begin
        if (time_q == PERIOD_LAST) begin
          time_d = '0;
          if (bit_q != '0) begin
            bit_d   = bit_q - BIT_W'(1);
            shift_d = {shift_q[BITS_PER_PIXEL-2:0], 1'b0};
          end else if (latch_q) begin
            state_d = ST_LATCH;
          end else if (!empty) begin
            // Chain straight into the next pixel so no extra low cycles appear.
            load = 1'b1;
          end else begin
`ifdef WS2812_AUTO_LATCH_EN
            state_d = ST_LATCH;
`else
            state_d = ST_IDLE;
`endif
          end
        end else begin
          time_d = time_q + CNT_W'(1);
        end
      end
      ST_LATCH: begin
        if (time_q == RESET_LAST) begin
          state_d = ST_IDLE;
          time_d  = '0;
        end else begin
          time_d = time_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_LATCH;
        time_d  = '0;
      end
    endcase
    if (load) begin
      state_d = ST_SEND;
      shift_d = rd_data[BITS_PER_PIXEL-1:0];
      latch_d = rd_data[BITS_PER_PIXEL];
      bit_d   = BIT_LAST;
      time_d  = '0;
    end
    pop = load;
  end

  // led follows the counter by one register stage, so SEND entry shows led high one cycle later.
  assign hi_len = shift_q[BITS_PER_PIXEL-1] ? T1H_LEN : T0H_LEN;
  assign led_d  = (state_q == ST_SEND) && (time_q < hi_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= ST_LATCH;
      time_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      latch_q  <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      time_q   <= time_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      latch_q  <= latch_d;
      led_q    <= led_d;
    end
  end

  assign ready      = !full;
  assign fifo_level = level_q;
  assign busy       = (state_q != ST_IDLE) || !empty;
  assign led        = led_q;

endmodule

// File: tb/tb_ws2812_stream_driver.sv
// Bench for ws2812_stream_driver: a 24-bit instance (main stream tests) and a 32-bit instance (RGBW pixel).
// A negedge monitor decodes the 24-bit led line and compares pixels against a scoreboard queue.
module tb_ws2812_stream_driver;

  localparam int W          = 24;
  localparam int RESET_CYC  = 20800;
  localparam int PERIOD_CYC = 80;
  localparam int T0H_CYC    = 26;
  localparam int T1H_CYC    = 51;
  localparam int PIX24      = 24 * PERIOD_CYC;

  logic        clk, rst_n, rst_n_b;
  logic [23:0] data_a;
  logic        latch_a, valid_a, ready, busy, led;
  logic [2:0]  fifo_level;
  logic [31:0] data_b;
  logic        latch_b, valid_b, ready_b, busy_b, led_b;
  logic [2:0]  fifo_level_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [23:0] data;
    logic        latch;
    int          exp_hi;
  } pix_vec_t;
  pix_vec_t vecs[4];

  ws2812_stream_driver dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_a), .latch_in(latch_a), .valid(valid_a),
    .ready(ready), .fifo_level(fifo_level), .busy(busy), .led(led)
  );

  ws2812_stream_driver #(.BITS_PER_PIXEL(32)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .data_in(data_b), .latch_in(latch_b), .valid(valid_b),
    .ready(ready_b), .fifo_level(fifo_level_b), .busy(busy_b), .led(led_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input bit sel, input logic [31:0] d, input logic l);
    int n = 0;
    while (!(sel ? ready_b : ready) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check(sel ? "push_ready_b" : "push_ready", sel ? ready_b : ready, 1);
    if (sel) begin
      data_b = d; latch_b = l; valid_b = 1'b1;
    end else begin
      data_a = d[23:0]; latch_a = l; valid_a = 1'b1;
      exp_q.push_back(d[23:0]);
    end
    @(posedge clk); #1;
    if (sel) valid_b = 1'b0;
    else valid_a = 1'b0;
  endtask

  task automatic count_busy(input bit sel, input int bound, output int n, output int led_hi);
    n = 0; led_hi = 0;
    forever begin
      @(negedge clk);
      if (!(sel ? busy_b : busy) || n >= bound) break;
      n++;
      if (sel ? led_b : led) led_hi++;
    end
  endtask

  task automatic wait_rise(input bit sel, input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!(sel ? led_b : led) && n < bound);
  endtask

  // Records led from the current (rising) negedge while busy, up to maxlen samples.
  task automatic capture(input bit sel, input int maxlen, output bit tr[$]);
    tr.delete();
    tr.push_back(sel ? led_b : led);
    while (tr.size() < maxlen) begin
      @(negedge clk);
      if (!(sel ? busy_b : busy)) break;
      tr.push_back(sel ? led_b : led);
    end
  endtask

  function automatic void analyze(input bit tr[$], output int rp[$], output int hw[$]);
    rp.delete(); hw.delete();
    for (int i = 0; i < tr.size(); i++) begin
      if (tr[i] && (i == 0 || !tr[i-1])) begin
        rp.push_back(i); hw.push_back(0);
      end
      if (tr[i]) hw[hw.size()-1] = hw[hw.size()-1] + 1;
    end
  endfunction

  int mon_hi = 0;
  int mon_bits = 0;
  logic [W-1:0] mon_pix = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_hi = 0; mon_bits = 0; mon_pix = '0;
    end else if (led) begin
      mon_hi++;
    end else if (mon_hi != 0) begin
      check("mon_pulse_width_legal", (mon_hi == T0H_CYC) || (mon_hi == T1H_CYC), 1);
      mon_pix = {mon_pix[W-2:0], (mon_hi == T1H_CYC)};
      mon_bits++;
      mon_hi = 0;
      if (mon_bits == W) begin
        mon_bits = 0;
        if (exp_q.size() == 0) check("sb_queue_has_pixel", exp_q.size(), 1);
        else check("sb_pixel", mon_pix, exp_q.pop_front());
      end
    end
  end

  task automatic seq_a();
    int n, hi, lat, bad, sum;
    bit tr[$];
    int rp[$], hw[$];
    // Power-up latch
    count_busy(0, RESET_CYC + 100, n, hi);
    check("t1_latch_len", n, RESET_CYC);
    check("t1_latch_led_low", hi, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_ready", ready, 1);
    check("t1_idle_level", fifo_level, 0);

    // Single latched pixel; busy spans 1919 samples of pixel from the first rise (led lags state by one) plus the latch.
    push(0, 32'h00A50000, 1'b1);
    wait_rise(0, 100, lat);
    check("t2_latency", lat, 3);
    capture(0, 30000, tr);
    analyze(tr, rp, hw);
    check("t2_total_len", tr.size(), PIX24 - 1 + RESET_CYC);
    check("t2_rises", rp.size(), 24);
    check("t2_bit0_hi", hw[0], T1H_CYC);
    check("t2_bit0_period", rp[1] - rp[0], PERIOD_CYC);
    check("t2_bit1_hi", hw[1], T0H_CYC);
    check("t2_bit1_period", rp[2] - rp[1], PERIOD_CYC);
    check("t2_last_bit_start", rp[23], 23 * PERIOD_CYC);
    check("t2_last_bit_hi", hw[23], T0H_CYC);
    check("t2_idle_ready", ready, 1);
    check("t2_idle_level", fifo_level, 0);

    // Underrun after a non-latch pixel
    push(0, 32'h0000FF00, 1'b0);
    wait_rise(0, 100, lat);
    check("t6_latency", lat, 3);
    capture(0, PIX24 + 280, tr);
    analyze(tr, rp, hw);
    check("t6_rises", rp.size(), 24);
`ifdef WS2812_AUTO_LATCH_EN
    check("t6_auto_latch_still_busy", tr.size(), PIX24 + 280);
    count_busy(0, RESET_CYC + 100, n, hi);
    check("t6_auto_latch_rest", n, PIX24 - 1 + RESET_CYC - (PIX24 + 280));
`else
    check("t6_underrun_len", tr.size(), PIX24 - 1);
    check("t6_idle_busy", busy, 0);
`endif

    // Asynchronous reset while a pixel is high, with a second pixel queued
    push(0, 32'h00C3C3C3, 1'b0);
    push(0, 32'h005A5A5A, 1'b0);
    wait_rise(0, 100, lat);
    repeat (100) @(negedge clk);
    check("t5_pre_led", led, 1);
    check("t5_pre_level", fifo_level, 1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t5_async_led", led, 0);
    check("t5_async_level", fifo_level, 0);
    check("t5_async_ready", ready, 1);
    check("t5_async_busy", busy, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill the FIFO during the post-reset latch, then stream four pixels back-to-back
    for (int k = 0; k < 4; k++) push(0, {8'h00, vecs[k].data}, vecs[k].latch);
    check("t3_full_ready", ready, 0);
    check("t3_full_level", fifo_level, 4);
    data_a = 24'hDEAD00; latch_a = 1'b0; valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
    check("t3_full_push_ignored", fifo_level, 4);
    // Release was one edge before the 1st push; latch ends 20800 edges after release, then pop and led rise.
    wait_rise(0, RESET_CYC + 100, lat);
    check("t3_latch_then_pop", lat, RESET_CYC - 2);
    check("t3_level_after_pop", fifo_level, 3);
    check("t3_ready_after_pop", ready, 1);
    capture(0, 4 * PIX24 + 200, tr);
    analyze(tr, rp, hw);
    check("t3_len_into_latch", tr.size(), 4 * PIX24 + 200);
    check("t3_rises", rp.size(), 96);
    bad = 0;
    for (int k = 0; k < rp.size(); k++) if (rp[k] != k * PERIOD_CYC) bad++;
    check("t3_contiguous_bits", bad, 0);
    for (int p = 0; p < 4; p++) begin
      sum = 0;
      for (int k = 24 * p; k < 24 * p + 24 && k < hw.size(); k++) sum += hw[k];
      check("t3_pixel_high_total", sum, vecs[p].exp_hi);
    end
    check("t3_latch_busy", busy, 1);
    check("t3_latch_led", led, 0);
  endtask

  task automatic seq_b();
    int n, hi, lat, bad;
    bit tr[$];
    int rp[$], hw[$];
    count_busy(1, RESET_CYC + 100, n, hi);
    check("t4_reset_latch", n, RESET_CYC);
    push(1, 32'h00000001, 1'b1);
    wait_rise(1, 100, lat);
    check("t4_latency", lat, 3);
    capture(1, 30000, tr);
    analyze(tr, rp, hw);
    check("t4_total_len", tr.size(), 32 * PERIOD_CYC - 1 + RESET_CYC);
    check("t4_rises", rp.size(), 32);
    bad = 0;
    for (int k = 0; k < 31 && k < hw.size(); k++) if (hw[k] != T0H_CYC) bad++;
    check("t4_zero_pulses", bad, 0);
    check("t4_last_hi", hw[31], T1H_CYC);
    check("t4_last_start", rp[31], 31 * PERIOD_CYC);
    check("t4_idle_level", fifo_level_b, 0);
  endtask

  initial begin
    vecs[0] = '{24'hFFFFFF, 1'b0, 24 * T1H_CYC};
    vecs[1] = '{24'h000000, 1'b0, 24 * T0H_CYC};
    vecs[2] = '{24'hA50000, 1'b0, 4 * T1H_CYC + 20 * T0H_CYC};
    vecs[3] = '{24'h0F0F01, 1'b1, 9 * T1H_CYC + 15 * T0H_CYC};
    rst_n = 1'b0; rst_n_b = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0;
    latch_a = 1'b0; latch_b = 1'b0;
    data_a = '0; data_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", led, 0);
    check("rst_ready", ready, 1);
    check("rst_level", fifo_level, 0);
    check("rst_busy", busy, 1);
    check("rst_led_b", led_b, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; rst_n_b = 1'b1;
    fork
      seq_a();
      seq_b();
    join
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
